// File: rtl/perf_window_ctrl.sv
// Measurement-window sequencer: counts total/PEB/MAC busy cycles between block start and done,
// and queues one record per closed window into a small FIFO drained over a valid/ready port.
module perf_window_ctrl #(
    parameter int CNT_W      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic                   cfg_clear,
    input  logic                   blk_start,
    input  logic                   blk_done,
    input  logic                   peb_busy,
    input  logic                   mac_busy,
    output logic                   rpt_val,
    input  logic                   rpt_rdy,
    output logic [17+3*CNT_W-1:0]  rpt_data,
    output logic                   win_active,
    output logic                   proto_err,
    output logic [15:0]            drop_cnt
);

    localparam int REC_W = 17 + 3 * CNT_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cyc_all_q, cyc_peb_q, cyc_mac_q;
    logic              ovf_q;
    logic [15:0]       win_idx_q;
    logic [15:0]       drop_cnt_q;
    logic              proto_err_q;
    logic [REC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

    logic              all_sat, peb_sat, mac_sat;
    logic [CNT_W-1:0]  cyc_all_d, cyc_peb_d, cyc_mac_d;
    logic              ovf_d;
    logic [REC_W-1:0]  rec_d;
    logic              fifo_full;
    logic              pop;

    // Next-cycle counts include this cycle's increments, so a record built
    // from them on the done cycle covers the done cycle itself.
    assign all_sat   = (cyc_all_q == CNT_MAX);
    assign peb_sat   = (cyc_peb_q == CNT_MAX);
    assign mac_sat   = (cyc_mac_q == CNT_MAX);
    assign cyc_all_d = all_sat ? cyc_all_q : cyc_all_q + CNT_W'(1);
    assign cyc_peb_d = (peb_busy && !peb_sat) ? cyc_peb_q + CNT_W'(1) : cyc_peb_q;
    assign cyc_mac_d = (mac_busy && !mac_sat) ? cyc_mac_q + CNT_W'(1) : cyc_mac_q;
    assign ovf_d     = ovf_q | all_sat | (peb_busy & peb_sat) | (mac_busy & mac_sat);
    assign rec_d     = {win_idx_q, ovf_d, cyc_all_d, cyc_peb_d, cyc_mac_d};

    assign fifo_full = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign rpt_val    = (wr_ptr_q != rd_ptr_q);
    assign rpt_data   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign pop        = rpt_val & rpt_rdy;
    assign win_active = (state_q == S_RUN);
    assign proto_err  = proto_err_q;
    assign drop_cnt   = drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cyc_all_q   <= '0;
            cyc_peb_q   <= '0;
            cyc_mac_q   <= '0;
            ovf_q       <= 1'b0;
            win_idx_q   <= '0;
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (cfg_clear) begin
            state_q     <= cfg_en ? S_WAIT : S_IDLE;
            cyc_all_q   <= '0;
            cyc_peb_q   <= '0;
            cyc_mac_q   <= '0;
            ovf_q       <= 1'b0;
            win_idx_q   <= '0;
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            if (!cfg_en) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: state_q <= S_WAIT;
                    S_WAIT: begin
                        if (blk_start) begin
                            state_q   <= S_RUN;
                            cyc_all_q <= '0;
                            cyc_peb_q <= '0;
                            cyc_mac_q <= '0;
                            ovf_q     <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (blk_done) begin
                            // Fullness is judged before any same-cycle pop.
                            if (fifo_full) begin
                                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                            end else begin
                                mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rec_d;
                                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                            end
                            win_idx_q <= win_idx_q + 16'd1;
                            if (blk_start) begin
                                cyc_all_q <= '0;
                                cyc_peb_q <= '0;
                                cyc_mac_q <= '0;
                                ovf_q     <= 1'b0;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end else begin
                            cyc_all_q <= cyc_all_d;
                            cyc_peb_q <= cyc_peb_d;
                            cyc_mac_q <= cyc_mac_d;
                            ovf_q     <= ovf_d;
                            if (blk_start) proto_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Bench for perf_window_ctrl: directed steps plus random traffic against a window/FIFO scoreboard.
module tb_perf_window_ctrl;

    localparam int CNT_W = 4;
    localparam int DLOG  = 2;
    localparam int DEPTH = 1 << DLOG;
    localparam int REC_W = 17 + 3 * CNT_W;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, cfg_en, cfg_clear, blk_start, blk_done, peb_busy, mac_busy, rpt_rdy;
    logic rpt_val, win_active, proto_err;
    logic [REC_W-1:0] rpt_data;
    logic [15:0] drop_cnt;

    perf_window_ctrl #(.CNT_W(CNT_W), .DEPTH_LOG2(DLOG)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_clear(cfg_clear),
        .blk_start(blk_start), .blk_done(blk_done), .peb_busy(peb_busy),
        .mac_busy(mac_busy), .rpt_val(rpt_val), .rpt_rdy(rpt_rdy),
        .rpt_data(rpt_data), .win_active(win_active), .proto_err(proto_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Scoreboard state, in terms of windows and queued records.
    logic [REC_W-1:0] q[$];
    int   m_idx, m_drop, n_all, n_peb, n_mac;
    logic m_perr, in_win, armed;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > MAXC) ? MAXC : n;
    endfunction

    function automatic logic [REC_W-1:0] mkrec(input int idx, input int a, input int p, input int m);
        logic [15:0] i16;
        logic [CNT_W-1:0] ca, cp, cm;
        logic o;
        i16 = idx[15:0];
        o   = (a > MAXC) || (p > MAXC) || (m > MAXC);
        ca  = sat(a);
        cp  = sat(p);
        cm  = sat(m);
        return {i16, o, ca, cp, cm};
    endfunction

    task automatic model_reset();
        q.delete();
        m_idx = 0; m_drop = 0; n_all = 0; n_peb = 0; n_mac = 0;
        m_perr = 0; in_win = 0; armed = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_val"}, rpt_val, (q.size() != 0));
        if (q.size() != 0) chk({tag, "_data"}, rpt_data, q[0]);
        chk({tag, "_act"}, win_active, in_win);
        chk({tag, "_drop"}, drop_cnt, m_drop);
        chk({tag, "_perr"}, proto_err, m_perr);
    endtask

    // One clock cycle: drive inputs, advance the scoreboard, then check after the edge.
    task automatic cyc(input logic s, input logic d, input logic p, input logic m, input logic r);
        logic do_pop;
        blk_start = s; blk_done = d; peb_busy = p; mac_busy = m; rpt_rdy = r;
        do_pop = (q.size() != 0) && r;
        if (cfg_clear) begin
            q.delete();
            m_idx = 0; m_drop = 0; m_perr = 0; in_win = 0; armed = cfg_en;
            n_all = 0; n_peb = 0; n_mac = 0;
        end else begin
            if (!cfg_en) begin
                in_win = 0;
                armed  = 0;
            end else begin
                if (in_win) begin
                    n_all++;
                    n_peb += p;
                    n_mac += m;
                end
                if (in_win && d) begin
                    if (q.size() == DEPTH) begin
                        if (m_drop < 16'hFFFF) m_drop++;
                    end else begin
                        q.push_back(mkrec(m_idx, n_all, n_peb, n_mac));
                    end
                    m_idx  = (m_idx + 1) & 16'hFFFF;
                    in_win = s;
                    n_all = 0; n_peb = 0; n_mac = 0;
                end else if (in_win && s) begin
                    m_perr = 1;
                end else if (!in_win && s && armed) begin
                    in_win = 1;
                    n_all = 0; n_peb = 0; n_mac = 0;
                end
                armed = 1;
            end
            if (do_pop) void'(q.pop_front());
        end
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic window(input int len, input logic all_busy);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < len; i++)
            cyc(0, (i == len - 1), all_busy | 1'($urandom), 1'($urandom), 0);
    endtask

    initial begin
        logic [9:0] peb_pat, mac_pat;
        int base_idx;

        rst = 1; cfg_en = 0; cfg_clear = 0; blk_start = 0; blk_done = 0;
        peb_busy = 0; mac_busy = 0; rpt_rdy = 0;
        model_reset();
        #12;
        chk("rst_val", rpt_val, 0);
        chk("rst_act", win_active, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_drop", drop_cnt, 0);
        #3 rst = 0;
        @(posedge clk); #1;

        cfg_en = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Basic window: 10 cycles, 7 PEB-busy, 4 MAC-busy.
        peb_pat = 10'b1110110110;
        mac_pat = 10'b1010100100;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, (i == 9), peb_pat[i], mac_pat[i], 0);
        chk("basic_val", rpt_val, 1);
        chk("basic_rec", rpt_data, {16'd0, 1'b0, 4'd10, 4'd7, 4'd4});
        cyc(0, 0, 0, 0, 1);
        chk("basic_popped", rpt_val, 0);

        // Back-to-back windows of 5 and 3 cycles.
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("b2b_active", win_active, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        chk("b2b_first", rpt_data, {16'd1, 1'b0, 4'd5, 4'd5, 4'd0});
        cyc(0, 0, 0, 0, 1);
        chk("b2b_second", rpt_data, {16'd2, 1'b0, 4'd3, 4'd0, 4'd3});
        cyc(0, 0, 0, 0, 1);

        // Six windows with no drain: four kept, two dropped.
        base_idx = m_idx;
        for (int w = 0; w < 6; w++) window(2, 0);
        chk("drop_cnt2", drop_cnt, 2);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 1'($urandom));
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        window(3, 0);
        chk("drop_next_idx", rpt_data[REC_W-1 -: 16], base_idx + 6);
        cyc(0, 0, 0, 0, 1);

        // Saturation with 4-bit counters, then a short clean window.
        window(20, 1);
        chk("sat_rec_hi", rpt_data[REC_W-17 -: 9], {1'b1, 4'd15, 4'd15});
        cyc(0, 0, 0, 0, 1);
        window(3, 0);
        chk("sat_clear_hi", rpt_data[REC_W-17 -: 5], {1'b0, 4'd3});
        cyc(0, 0, 0, 0, 1);

        // Random traffic including protocol errors and concurrent push/pop.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

        // Abort: dropping cfg_en mid-window leaves no record.
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cfg_en = 0;
        cyc(0, 1, 0, 0, 0);
        chk("abort_idle", win_active, 0);
        cfg_en = 1;
        cyc(0, 0, 0, 0, 0);
        window(2, 0);
        cyc(0, 0, 0, 0, 1);

        // Clear with two queued records and proto_err set.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        window(2, 0);
        chk("clr_pre_perr", proto_err, 1);
        cfg_clear = 1;
        cyc(1, 0, 0, 0, 0);
        cfg_clear = 0;
        chk("clr_val", rpt_val, 0);
        chk("clr_perr", proto_err, 0);
        chk("clr_drop", drop_cnt, 0);
        window(2, 0);
        chk("clr_idx", rpt_data[REC_W-1 -: 16], 0);

        // Asynchronous reset mid-window with records queued.
        window(2, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        #2 rst = 1;
        #1;
        chk("arst_val", rpt_val, 0);
        chk("arst_act", win_active, 0);
        chk("arst_data", rpt_data, 0);
        chk("arst_drop", drop_cnt, 0);
        chk("arst_perr", proto_err, 0);
        cfg_en = 0; blk_start = 0; blk_done = 0;
        #4 rst = 0;
        model_reset();
        @(posedge clk); #1;
        cfg_en = 1;
        cyc(0, 0, 0, 0, 0);
        window(4, 0);
        chk("arst_idx", rpt_data[REC_W-1 -: 16], 0);
        cyc(0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
